lacc_mem_responder: RTL and testbench

//  Memory-side responder for the accelerator lacc_data_*/lacc_drsp_* request interface.

---
 rtl/lacc_mem_pkg.sv | 29 ++
 rtl/lacc_mem_responder_if.sv | 24 ++
 rtl/lacc_mem_lfsr.sv | 26 ++
 rtl/lacc_mem_responder.sv | 143 ++++++++++++++
 tb/tb_lacc_mem_responder.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lacc_mem_pkg.sv
// rtl/lacc_mem_pkg.sv - shared encodings, FSM states, LFSR constants and byte-enable helper
// for the lacc memory responder.
package lacc_mem_pkg;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_BAD = 2'b11;

  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // Left-shifting Fibonacci form: bits 15,13,12,10 are polynomial taps 16,14,13,11.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SIZE_B:  be = 4'b0001 << lane;
      SIZE_H:  be = lane[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lacc_mem_responder_if.sv
// rtl/lacc_mem_responder_if.sv - lacc_data request / lacc_drsp response bundle
// between the accelerator (master) and the memory responder (slave).
interface lacc_mem_responder_if;

  logic        lacc_data_valid;
  logic        lacc_data_ready;
  logic [31:0] lacc_data_addr;
  logic        lacc_data_read;
  logic [31:0] lacc_data_wdata;
  logic [1:0]  lacc_data_size;
  logic        lacc_drsp_valid;
  logic [31:0] lacc_drsp_rdata;

  modport master (
    output lacc_data_valid, lacc_data_addr, lacc_data_read, lacc_data_wdata, lacc_data_size,
    input  lacc_data_ready, lacc_drsp_valid, lacc_drsp_rdata
  );

  modport slave (
    input  lacc_data_valid, lacc_data_addr, lacc_data_read, lacc_data_wdata, lacc_data_size,
    output lacc_data_ready, lacc_drsp_valid, lacc_drsp_rdata
  );

endinterface

// File: rtl/lacc_mem_lfsr.sv
// rtl/lacc_mem_lfsr.sv - 16-bit Fibonacci LFSR producing a registered ~25% stall;
// only used when LACC_MEM_STALL_EN is defined.
module lacc_mem_lfsr
  import lacc_mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic step,
  output logic stall
);

  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr  <= LFSR_SEED;
      stall <= 1'b0;
    end else begin
      if (step) begin
        lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
      end
      stall <= (lfsr[1:0] == 2'b00);
    end
  end

endmodule

// File: rtl/lacc_mem_responder.sv
// rtl/lacc_mem_responder.sv - lacc request responder over a local word SRAM with host side-port;
// LACC_MEM_STALL_EN adds pseudo-random back-pressure on lacc_data_ready.
module lacc_mem_responder
  import lacc_mem_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  lacc_mem_responder_if.slave     bus,
  input  logic                    host_en,
  input  logic                    host_we,
  input  logic [ADDR_WIDTH-1:0]   host_addr,
  input  logic [31:0]             host_wdata,
  output logic [31:0]             host_rdata,
  output logic                    init_done,
  output logic                    err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [31:0]           mem [DEPTH];
  logic                  run;
  logic                  stall;

  assign run = (state == RUN);

`ifdef LACC_MEM_STALL_EN
  lacc_mem_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (run),
    .stall (stall)
  );
`else
  assign stall = 1'b0;
`endif

  // ready never looks at lacc_data_valid, so masters may wait on it safely.
  assign bus.lacc_data_ready = ~rst & run & ~host_en & ~stall;

  logic                  hsk;
  logic [ADDR_WIDTH-1:0] widx;
  logic                  in_win;
  logic                  misaligned;
  logic                  illegal;
  logic                  rd_hsk;
  logic                  wr_hsk;
  logic                  host_wr;
  logic                  host_rd;

  assign hsk        = bus.lacc_data_valid & bus.lacc_data_ready;
  assign widx       = bus.lacc_data_addr[ADDR_WIDTH+1:2];
  assign in_win     = bus.lacc_data_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2];
  assign misaligned = ((bus.lacc_data_size == SIZE_H) & bus.lacc_data_addr[0]) |
                      ((bus.lacc_data_size == SIZE_W) & (|bus.lacc_data_addr[1:0]));
  assign illegal    = (bus.lacc_data_size == SIZE_BAD) | misaligned | ~in_win;
  assign rd_hsk     = hsk & bus.lacc_data_read;
  assign wr_hsk     = hsk & ~bus.lacc_data_read & ~illegal;
  assign host_wr    = run & host_en & host_we;
  assign host_rd    = run & host_en & ~host_we;

  // Single write port shared by the clear sweep, the host and the lacc port.
  logic [3:0]            w_be;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [31:0]           w_data;
  logic [31:0]           lane_data;

  always_comb begin
    lane_data = bus.lacc_data_wdata;
    case (bus.lacc_data_size)
      SIZE_B:  lane_data = {4{bus.lacc_data_wdata[7:0]}};
      SIZE_H:  lane_data = {2{bus.lacc_data_wdata[15:0]}};
      default: lane_data = bus.lacc_data_wdata;
    endcase
  end

  always_comb begin
    w_be   = 4'b0000;
    w_idx  = cnt;
    w_data = 32'h0;
    if (!run) begin
      w_be = 4'b1111;
    end else if (host_wr) begin
      w_be   = 4'b1111;
      w_idx  = host_addr;
      w_data = host_wdata;
    end else if (wr_hsk) begin
      w_be   = be_gen(bus.lacc_data_size, bus.lacc_data_addr[1:0]);
      w_idx  = widx;
      w_data = lane_data;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_be[b]) begin
        mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

  // Host and lacc reads never coincide (ready is low while host_en), so one read port serves both.
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [31:0]           r_word;

  assign r_idx  = host_rd ? host_addr : widx;
  assign r_word = mem[r_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= INIT;
      cnt                 <= '0;
      init_done           <= 1'b0;
      err                 <= 1'b0;
      bus.lacc_drsp_valid <= 1'b0;
      bus.lacc_drsp_rdata <= 32'h0;
      host_rdata          <= 32'h0;
    end else begin
      bus.lacc_drsp_valid <= rd_hsk;
      if (rd_hsk) begin
        bus.lacc_drsp_rdata <= illegal ? 32'h0 : r_word;
      end
      if (host_rd) begin
        host_rdata <= r_word;
      end
      if (hsk & illegal) begin
        err <= 1'b1;
      end
      if (!run) begin
        cnt <= cnt + 1'b1;
        if (cnt == {ADDR_WIDTH{1'b1}}) begin
          state     <= RUN;
          init_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lacc_mem_responder.sv
// tb/tb_lacc_mem_responder.sv - directed and random stimulus for lacc_mem_responder
// against a word-array reference model; honours LACC_MEM_STALL_EN.
module tb_lacc_mem_responder;

  localparam int          AW    = 12;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          host_en;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_wdata;
  logic [31:0]   host_rdata;
  logic          init_done;
  logic          err;

  lacc_mem_responder_if bus ();

  lacc_mem_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .host_en    (host_en),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .init_done  (init_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int waits    = 0;

  logic [31:0] mm [DEPTH];
  bit          run_m;
  int          init_cnt;
  bit          err_m;
  logic [31:0] hr_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit legal_req(input logic [31:0] a, input logic [1:0] sz);
    int nb;
    if (sz == 2'b11) return 1'b0;
    nb = 1 << sz;
    if ((int'(a[1:0]) % nb) != 0) return 1'b0;
    return (a >> (AW + 2)) == (BASE >> (AW + 2));
  endfunction

  // One clock: evaluate request/host activity before the edge, check outputs after it.
  task automatic clk_cycle(output bit hsk);
    bit          exp_rdy, exp_dv;
    logic [31:0] a, exp_rd, wd;
    logic [1:0]  sz;
    int          idx, nb, lane;
    #1;
    exp_rdy = !rst && run_m && !host_en;
`ifdef LACC_MEM_STALL_EN
    chk("ready_gate", {31'b0, bus.lacc_data_ready & ~exp_rdy}, 32'h0);
`else
    chk("ready", {31'b0, bus.lacc_data_ready}, {31'b0, exp_rdy});
`endif
    hsk    = bus.lacc_data_valid && bus.lacc_data_ready;
    exp_dv = 1'b0;
    exp_rd = 32'h0;
    if (rst) begin
      run_m    = 1'b0;
      init_cnt = 0;
      err_m    = 1'b0;
      hr_m     = 32'h0;
      for (int i = 0; i < DEPTH; i++) mm[i] = 32'h0;
    end else if (!run_m) begin
      init_cnt++;
      if (init_cnt == DEPTH) run_m = 1'b1;
    end else begin
      if (hsk) begin
        a   = bus.lacc_data_addr;
        sz  = bus.lacc_data_size;
        wd  = bus.lacc_data_wdata;
        idx = int'((a >> 2) % DEPTH);
        if (!legal_req(a, sz)) err_m = 1'b1;
        if (bus.lacc_data_read) begin
          exp_dv = 1'b1;
          exp_rd = legal_req(a, sz) ? mm[idx] : 32'h0;
        end else if (legal_req(a, sz)) begin
          nb = 1 << sz;
          for (int k = 0; k < nb; k++) begin
            lane = int'(a[1:0]) + k;
            mm[idx][lane*8 +: 8] = wd[k*8 +: 8];
          end
        end
      end
      if (host_en) begin
        if (host_we) mm[host_addr] = host_wdata;
        else         hr_m = mm[host_addr];
      end
    end
    @(posedge clk);
    #1;
    chk("drsp_valid", {31'b0, bus.lacc_drsp_valid}, {31'b0, exp_dv});
    if (exp_dv || rst) chk("drsp_rdata", bus.lacc_drsp_rdata, exp_rd);
    chk("host_rdata", host_rdata, hr_m);
    chk("init_done", {31'b0, init_done}, {31'b0, run_m});
    chk("err", {31'b0, err}, {31'b0, err_m});
    @(negedge clk);
  endtask

  task automatic req(input bit rd, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    bit h;
    int w;
    bus.lacc_data_valid = 1'b1;
    bus.lacc_data_read  = rd;
    bus.lacc_data_addr  = a;
    bus.lacc_data_size  = sz;
    bus.lacc_data_wdata = wd;
    w = 0;
    do begin
      clk_cycle(h);
      w++;
    end while (!h && w < 100);
    chk("req_hsk", {31'b0, h}, 32'h1);
    waits += w - 1;
    bus.lacc_data_valid = 1'b0;
  endtask

  task automatic wait_init(input string tag);
    bit h;
    int w;
    bus.lacc_data_valid = 1'b1;
    bus.lacc_data_read  = 1'b1;
    bus.lacc_data_addr  = 32'h0;
    bus.lacc_data_size  = 2'b10;
    w = 0;
    do begin
      clk_cycle(h);
      if (!h) w++;
    end while (!h && w < DEPTH + 500);
    chk(tag, w, DEPTH);
    chk({tag, "_rdata"}, bus.lacc_drsp_rdata, 32'h0);
    bus.lacc_data_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          h;
    int          r, pct;
    logic [31:0] a;
    logic [1:0]  sz;

    rst                 = 1'b1;
    host_en             = 1'b0;
    host_we             = 1'b0;
    host_addr           = '0;
    host_wdata          = 32'h0;
    bus.lacc_data_valid = 1'b0;
    bus.lacc_data_read  = 1'b0;
    bus.lacc_data_addr  = 32'h0;
    bus.lacc_data_wdata = 32'h0;
    bus.lacc_data_size  = 2'b00;

    // Reset state, then the clear sweep holds ready low for DEPTH cycles.
    repeat (3) clk_cycle(h);
    rst = 1'b0;
    wait_init("t1_init_wait");

    // Word write then read on the following cycle.
    req(1'b0, 32'h10, 2'b10, 32'hDEADBEEF);
    req(1'b1, 32'h10, 2'b10, 32'h0);
    chk("t2_rdata", bus.lacc_drsp_rdata, 32'hDEADBEEF);

    // Byte and half-word lane writes.
    req(1'b0, 32'h13, 2'b00, 32'h000000AB);
    req(1'b0, 32'h10, 2'b01, 32'h00001234);
    req(1'b1, 32'h10, 2'b10, 32'h0);
    chk("t3_rdata", bus.lacc_drsp_rdata, 32'hABAD1234);

    // Illegal accesses: misaligned write dropped, bad size and out-of-window reads give 0.
    req(1'b0, 32'h2, 2'b10, 32'h55555555);
    req(1'b1, 32'h0, 2'b10, 32'h0);
    chk("t4_err", {31'b0, err}, 32'h1);
    chk("t4_mem0", bus.lacc_drsp_rdata, 32'h0);
    req(1'b1, 32'h10, 2'b11, 32'h0);
    chk("t4_bad_size_rdata", bus.lacc_drsp_rdata, 32'h0);
    req(1'b1, 32'h0000_4010, 2'b10, 32'h0);
    chk("t4_out_win_rdata", bus.lacc_drsp_rdata, 32'h0);
    chk("t4_err_sticky", {31'b0, err}, 32'h1);

    // Host write beats a simultaneous lacc read; the read then sees the host data.
    host_en             = 1'b1;
    host_we             = 1'b1;
    host_addr           = AW'(5);
    host_wdata          = 32'hC0FFEE05;
    bus.lacc_data_valid = 1'b1;
    bus.lacc_data_read  = 1'b1;
    bus.lacc_data_addr  = 32'h14;
    bus.lacc_data_size  = 2'b10;
    clk_cycle(h);
    chk("t5_no_hsk", {31'b0, h}, 32'h0);
    host_en = 1'b0;
    req(1'b1, 32'h14, 2'b10, 32'h0);
    chk("t5_rdata", bus.lacc_drsp_rdata, 32'hC0FFEE05);
    host_en   = 1'b1;
    host_we   = 1'b0;
    host_addr = AW'(4);
    clk_cycle(h);
    host_en = 1'b0;
    chk("t5_host_rdata", host_rdata, 32'hABAD1234);

    // Random mix of lacc reads/writes (some illegal) and host accesses.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        host_en    = 1'b1;
        host_we    = 1'($urandom_range(0, 1));
        host_addr  = AW'($urandom_range(0, 63));
        host_wdata = $urandom;
        clk_cycle(h);
        host_en = 1'b0;
      end else begin
        a = 32'($urandom_range(0, 255));
        if (r == 9) a = a | 32'h0001_0000;
        sz = (r == 8) ? 2'b11 : 2'($urandom_range(0, 2));
        req(1'($urandom_range(0, 1)), a, sz, $urandom);
      end
    end

    // Preload through the host port, then a long back-to-back read burst.
    for (int i = 0; i < 1000; i++) begin
      host_en    = 1'b1;
      host_we    = 1'b1;
      host_addr  = AW'(i);
      host_wdata = 32'(i * 3);
      clk_cycle(h);
    end
    host_en = 1'b0;
    waits   = 0;
    for (int i = 0; i < 1000; i++) begin
      req(1'b1, 32'(i * 4), 2'b10, 32'h0);
    end
    chk("t6_last_rdata", bus.lacc_drsp_rdata, 32'(999 * 3));
`ifdef LACC_MEM_STALL_EN
    pct = (waits * 100) / (1000 + waits);
    chk("t6_stall_pct_in_range", {31'b0, (pct >= 20 && pct <= 30)}, 32'h1);
`else
    chk("t6_no_stall", waits, 0);
`endif

    // Reset with a response in flight drops it, then the memory is swept again.
    req(1'b1, 32'hC, 2'b10, 32'h0);
    bus.lacc_data_valid = 1'b1;
    rst = 1'b1;
    clk_cycle(h);
    chk("t6_rst_drop", {31'b0, bus.lacc_drsp_valid}, 32'h0);
    clk_cycle(h);
    rst = 1'b0;
    wait_init("t6_reinit_wait");
    req(1'b1, 32'hC, 2'b10, 32'h0);
    chk("t6_reinit_cleared", bus.lacc_drsp_rdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
